// File: rtl/muldiv_pkg.sv
// Shared types and op decode helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_e;

  function automatic logic is_div(op_e op);
    return op[2];
  endfunction

  function automatic logic is_rem(op_e op);
    return op[2] & op[1];
  endfunction

  function automatic logic is_signed_a(op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic want_high(op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between a core (master) and the multiply/divide unit (slave).
interface muldiv_if #(parameter int XLEN = 32);
  logic            start;
  logic            kill;
  logic [2:0]      funct3;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, kill, funct3, a, b, input busy, done, result);
  modport slave  (input start, kill, funct3, a, b, output busy, done, result);
endinterface

// File: rtl/muldiv_step.sv
// Combinational datapath: BPC shift-add (multiply) or restore-subtract (divide) steps
// on the {acc, opnd} pair, with `other` as multiplicand or divisor.
module muldiv_step #(
  parameter int XLEN = 32,
  parameter int BPC  = 1
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] acc_in,
  input  logic [XLEN-1:0] opnd_in,
  input  logic [XLEN-1:0] other,
  output logic [XLEN-1:0] acc_out,
  output logic [XLEN-1:0] opnd_out
);

  logic [BPC:0][XLEN-1:0] acc_s;
  logic [BPC:0][XLEN-1:0] opnd_s;

  assign acc_s[0]  = acc_in;
  assign opnd_s[0] = opnd_in;

  // Multiply shifts the product right; divide shifts the remainder left.
  // The remainder is always below the divisor, so the shifted value fits in XLEN+1 bits
  // and the low XLEN bits of the difference are exact when it does not borrow.
  for (genvar i = 0; i < BPC; i++) begin : g_step
    logic [XLEN:0] sum;
    logic [XLEN:0] rem_sh;
    logic          ge;

    assign sum    = {1'b0, acc_s[i]} + (opnd_s[i][0] ? {1'b0, other} : {(XLEN+1){1'b0}});
    assign rem_sh = {acc_s[i], opnd_s[i][XLEN-1]};
    assign ge     = rem_sh >= {1'b0, other};

    assign acc_s[i+1]  = is_div ? (ge ? rem_sh[XLEN-1:0] - other : rem_sh[XLEN-1:0])
                                : sum[XLEN:1];
    assign opnd_s[i+1] = is_div ? {opnd_s[i][XLEN-2:0], ge}
                                : {sum[0], opnd_s[i][XLEN-1:1]};
  end

  assign acc_out  = acc_s[BPC];
  assign opnd_out = opnd_s[BPC];

endmodule

// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide unit with start/busy/done handshake and kill.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input logic     clk,
  input logic     reset,
  muldiv_if.slave bus
);

  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0]   LAST     = CW'(N - 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state, state_next;
  logic [CW-1:0]     cnt;
  op_e               op;
  logic [XLEN-1:0]   acc, opnd, other;
  logic              neg;
  logic [XLEN-1:0]   result_q;

  op_e               op_in;
  logic              sign_a, sign_b, div_zero, div_ovf, fast, accept, neg_in;
  logic [XLEN-1:0]   mag_a, mag_b, acc_step, opnd_step;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   q_fix, r_fix, fix_result;

  assign op_in    = op_e'(bus.funct3);
  assign sign_a   = is_signed_a(op_in) & bus.a[XLEN-1];
  assign sign_b   = is_signed_b(op_in) & bus.b[XLEN-1];
  assign mag_a    = sign_a ? -bus.a : bus.a;
  assign mag_b    = sign_b ? -bus.b : bus.b;
  assign div_zero = is_div(op_in) && (bus.b == '0);
  assign div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM)) && (bus.a == MOST_NEG) && (bus.b == '1);
  assign fast     = div_zero | div_ovf;
  assign neg_in   = is_rem(op_in) ? sign_a : (sign_a ^ sign_b);
  assign accept   = bus.start && !bus.kill && ((state == S_IDLE) || (state == S_DONE));

  muldiv_step #(.XLEN(XLEN), .BPC(BITS_PER_CYCLE)) u_step (
    .is_div   (is_div(op)),
    .acc_in   (acc),
    .opnd_in  (opnd),
    .other    (other),
    .acc_out  (acc_step),
    .opnd_out (opnd_step)
  );

  // Multiply leaves the product in {acc, opnd}; divide leaves remainder in acc, quotient in opnd.
  assign prod       = {acc, opnd};
  assign prod_fix   = neg ? -prod : prod;
  assign q_fix      = neg ? -opnd : opnd;
  assign r_fix      = neg ? -acc : acc;
  assign fix_result = is_div(op) ? (is_rem(op) ? r_fix : q_fix)
                                 : (want_high(op) ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: state_next = accept ? (fast ? S_FIX : S_RUN) : S_IDLE;
      S_RUN:          if (bus.kill) state_next = S_IDLE;
                      else if (cnt == LAST) state_next = S_FIX;
      S_FIX:          state_next = bus.kill ? S_IDLE : S_DONE;
      default:        state_next = S_IDLE;
    endcase
  end

  // Fast-path ops preload {acc, opnd} with the final remainder/quotient so FIX just selects.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      op       <= OP_MUL;
      acc      <= '0;
      opnd     <= '0;
      other    <= '0;
      neg      <= 1'b0;
      result_q <= '0;
    end else begin
      if (accept) begin
        op  <= op_in;
        cnt <= '0;
        if (div_zero) begin
          acc  <= bus.a;
          opnd <= '1;
          neg  <= 1'b0;
        end else if (div_ovf) begin
          acc  <= '0;
          opnd <= bus.a;
          neg  <= 1'b0;
        end else begin
          acc   <= '0;
          opnd  <= is_div(op_in) ? mag_a : mag_b;
          other <= is_div(op_in) ? mag_b : mag_a;
          neg   <= neg_in;
        end
      end else if ((state == S_RUN) && !bus.kill) begin
        acc  <= acc_step;
        opnd <= opnd_step;
        cnt  <= (cnt == LAST) ? '0 : cnt + CW'(1);
      end
      if ((state == S_FIX) && !bus.kill) result_q <= fix_result;
    end
  end

  assign bus.busy   = (state == S_RUN) || (state == S_FIX);
  assign bus.done   = (state == S_DONE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed self-checking bench for muldiv_iter at BITS_PER_CYCLE 1 and 4.
module tb_muldiv_iter;
  import muldiv_pkg::*;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  muldiv_if #(.XLEN(32)) bus1 ();
  muldiv_if #(.XLEN(32)) bus4 ();

  muldiv_iter #(.XLEN(32), .BITS_PER_CYCLE(1)) u1 (.clk(clk), .reset(reset), .bus(bus1));
  muldiv_iter #(.XLEN(32), .BITS_PER_CYCLE(4)) u4 (.clk(clk), .reset(reset), .bus(bus4));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic get_busy(bit sel);
    return sel ? bus4.busy : bus1.busy;
  endfunction

  function automatic logic get_done(bit sel);
    return sel ? bus4.done : bus1.done;
  endfunction

  function automatic logic [31:0] get_result(bit sel);
    return sel ? bus4.result : bus1.result;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Presents one request for a single cycle; returns 1 time unit after edge 0.
  task automatic applyStimulus(input bit sel, input op_e op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    if (sel) begin
      bus4.start = 1'b1; bus4.funct3 = op; bus4.a = a; bus4.b = b;
    end else begin
      bus1.start = 1'b1; bus1.funct3 = op; bus1.a = a; bus1.b = b;
    end
    @(posedge clk);
    #1;
    bus1.start = 1'b0;
    bus4.start = 1'b0;
  endtask

  // Counts edges after edge 0 until done is seen; -1 on timeout.
  task automatic waitDone(input bit sel, output int lat);
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      #1;
      if (get_done(sel)) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic runOp(input string tag, input bit sel, input op_e op, input logic [31:0] a,
                       input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
    int lat;
    applyStimulus(sel, op, a, b);
    checkOutput({tag, "_busy"}, 32'(get_busy(sel)), 32'd1);
    waitDone(sel, lat);
    checkOutput({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, "_res"}, get_result(sel), exp_res);
  endtask

  initial begin
    int lat;
    int done_seen;

    reset = 1'b0;
    bus1.start = 1'b0; bus1.kill = 1'b0; bus1.funct3 = 3'b000; bus1.a = '0; bus1.b = '0;
    bus4.start = 1'b0; bus4.kill = 1'b0; bus4.funct3 = 3'b000; bus4.a = '0; bus4.b = '0;
    #12;
    checkOutput("rst_busy", 32'(bus1.busy), 32'd0);
    checkOutput("rst_done", 32'(bus1.done), 32'd0);
    checkOutput("rst_result", bus1.result, 32'd0);
    checkOutput("rst4_result", bus4.result, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Basic multiply, then the done pulse must last exactly one cycle with result held.
    runOp("mul", 1'b0, OP_MUL, 32'd7, 32'hFFFF_FFFD, 33, 32'hFFFF_FFEB);
    @(posedge clk);
    #1;
    checkOutput("mul_done_pulse", 32'(bus1.done), 32'd0);
    checkOutput("mul_hold", bus1.result, 32'hFFFF_FFEB);

    runOp("mulhu", 1'b0, OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE);
    runOp("mulh", 1'b0, OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'h0000_0000);
    runOp("mulhsu", 1'b0, OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFF);

    // DIV then REM issued straight out of DONE.
    runOp("div", 1'b0, OP_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD);
    runOp("rem_b2b", 1'b0, OP_REM, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF);
    checkOutput("rem_b2b_done", 32'(bus1.done), 32'd1);

    runOp("div_ovf", 1'b0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
    runOp("rem_ovf", 1'b0, OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0000_0000);
    runOp("divu_z", 1'b0, OP_DIVU, 32'd25, 32'd0, 1, 32'hFFFF_FFFF);
    runOp("remu_z", 1'b0, OP_REMU, 32'd25, 32'd0, 1, 32'h0000_0019);

    // Kill during RUN cycle 10: no done, result untouched, unit idle.
    applyStimulus(1'b0, OP_DIV, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus1.kill = 1'b1;
    @(posedge clk);
    #1;
    bus1.kill = 1'b0;
    checkOutput("kill_busy", 32'(bus1.busy), 32'd0);
    checkOutput("kill_done", 32'(bus1.done), 32'd0);
    checkOutput("kill_result", bus1.result, 32'h0000_0019);
    done_seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus1.done) done_seen++;
    end
    checkOutput("kill_no_done", 32'(done_seen), 32'd0);
    runOp("after_kill", 1'b0, OP_DIVU, 32'd100, 32'd7, 33, 32'd14);

    // A start pulse while busy must not disturb the operation in flight.
    applyStimulus(1'b0, OP_MUL, 32'd3, 32'd5);
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus1.start = 1'b1; bus1.funct3 = OP_DIVU; bus1.a = 32'd100; bus1.b = 32'd0;
    @(posedge clk);
    #1;
    bus1.start = 1'b0;
    checkOutput("ign_busy", 32'(bus1.busy), 32'd1);
    waitDone(1'b0, lat);
    checkOutput("ign_lat", 32'(lat), 32'd28);
    checkOutput("ign_res", bus1.result, 32'd15);

    // Asynchronous reset in the middle of RUN.
    applyStimulus(1'b0, OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("arst_busy", 32'(bus1.busy), 32'd0);
    checkOutput("arst_done", 32'(bus1.done), 32'd0);
    checkOutput("arst_result", bus1.result, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    runOp("post_rst", 1'b0, OP_MUL, 32'd7, 32'hFFFF_FFFD, 33, 32'hFFFF_FFEB);

    runOp("bpc4_mul", 1'b1, OP_MUL, 32'd7, 32'hFFFF_FFFD, 9, 32'hFFFF_FFEB);
    runOp("bpc4_div", 1'b1, OP_DIV, 32'hFFFF_FFF9, 32'd2, 9, 32'hFFFF_FFFD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
